sweep_sequencer: RTL

Frequency-sweep controller for the downconversion chain. It owns the downconversion phase increment, steps it across a CPU-programmed range, and waits a settle interval per step for CORDIC/decimator latency. It then averages 2^k decimated I/Q samples and hands each per-step result to the CPU through a valid/ready port. It sits between the CSR block and the downconversion phase accumulator, and taps the downsampler outputs and their `ce_down` strobe.

---
 rtl/sweep_sequencer_if.sv | 22 ++
 rtl/sweep_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_sequencer_if.sv
// Result handshake bundle between the sweep sequencer and the CPU-side consumer.
interface sweep_sequencer_if #(
  parameter int PW = 19,
  parameter int DW = 16
);
  logic                 res_valid;
  logic                 res_ready;
  logic [15:0]          res_idx;
  logic [PW-1:0]        res_inc;
  logic signed [DW-1:0] res_x;
  logic signed [DW-1:0] res_y;

  modport master (
    output res_valid, res_idx, res_inc, res_x, res_y,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_idx, res_inc, res_x, res_y,
    output res_ready
  );
endinterface

// File: rtl/sweep_sequencer.sv
// Frequency-sweep controller: steps the downconversion phase increment, waits a
// settle interval of decimated strobes, averages 2^k I/Q samples and offers
// each per-step average on a valid/ready port.
module sweep_sequencer #(
  parameter int PW = 19,
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PW-1:0]        cfg_f_start,
  input  logic [PW-1:0]        cfg_f_step,
  input  logic [15:0]          cfg_n_steps,
  input  logic [CW-1:0]        cfg_settle,
  input  logic [3:0]           cfg_avg_log2,
  input  logic                 ce_down,
  input  logic signed [DW-1:0] sample_x,
  input  logic signed [DW-1:0] sample_y,
  output logic [PW-1:0]        phase_inc_down,
  sweep_sequencer_if.master    res,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int AW = DW + 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // Averaging depth above 10 would overflow the DW+10 accumulator, so cap it.
  function automatic logic [3:0] clamp_k(input logic [3:0] k);
    return (k > 4'd10) ? 4'd10 : k;
  endfunction

  state_t               state_r, state_nx;
  logic [PW-1:0]        phase_r, phase_nx;
  logic [PW-1:0]        step_r, step_nx;
  logic [15:0]          nsteps_r, nsteps_nx;
  logic [CW-1:0]        settle_r, settle_nx;
  logic [3:0]           k_r, k_nx;
  logic [15:0]          idx_r, idx_nx;
  logic [CW-1:0]        scnt_r, scnt_nx;
  logic [10:0]          acnt_r, acnt_nx;
  logic signed [AW-1:0] acc_x_r, acc_x_nx, acc_y_r, acc_y_nx;
  logic signed [AW-1:0] sum_x_s, sum_y_s;
  logic [10:0]          acc_last_s;
  logic                 resv_r, resv_nx;
  logic [15:0]          res_idx_r, res_idx_nx;
  logic [PW-1:0]        res_inc_r, res_inc_nx;
  logic signed [DW-1:0] res_x_r, res_x_nx, res_y_r, res_y_nx;
  logic                 busy_r, done_r, done_nx, ovr_r, ovr_nx;

  assign sum_x_s    = acc_x_r + {{10{sample_x[DW-1]}}, sample_x};
  assign sum_y_s    = acc_y_r + {{10{sample_y[DW-1]}}, sample_y};
  assign acc_last_s = (11'd1 << k_r) - 11'd1;

  // Next-state and next-datapath decode; abort overrides every state.
  always_comb begin
    state_nx   = state_r;
    phase_nx   = phase_r;
    step_nx    = step_r;
    nsteps_nx  = nsteps_r;
    settle_nx  = settle_r;
    k_nx       = k_r;
    idx_nx     = idx_r;
    scnt_nx    = scnt_r;
    acnt_nx    = acnt_r;
    acc_x_nx   = acc_x_r;
    acc_y_nx   = acc_y_r;
    resv_nx    = resv_r;
    res_idx_nx = res_idx_r;
    res_inc_nx = res_inc_r;
    res_x_nx   = res_x_r;
    res_y_nx   = res_y_r;
    done_nx    = 1'b0;
    ovr_nx     = ovr_r;
    if (abort) begin
      state_nx = IDLE;
      resv_nx  = 1'b0;
      scnt_nx  = CW'(0);
      acnt_nx  = 11'd0;
      acc_x_nx = AW'(0);
      acc_y_nx = AW'(0);
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (cfg_n_steps == 16'd0) begin
              done_nx = 1'b1;
            end else begin
              step_nx   = cfg_f_step;
              nsteps_nx = cfg_n_steps;
              settle_nx = cfg_settle;
              k_nx      = clamp_k(cfg_avg_log2);
              phase_nx  = cfg_f_start;
              idx_nx    = 16'd0;
              scnt_nx   = CW'(0);
              ovr_nx    = 1'b0;
              state_nx  = SETTLE;
            end
          end else begin
            state_nx = IDLE;
          end
        end
        SETTLE: begin
          if (settle_r == CW'(0)) begin
            state_nx = ACCUM;
            acnt_nx  = 11'd0;
            acc_x_nx = AW'(0);
            acc_y_nx = AW'(0);
          end else if (ce_down) begin
            // The strobe that completes the settle interval is discarded.
            if (scnt_r == settle_r - CW'(1)) begin
              state_nx = ACCUM;
              scnt_nx  = CW'(0);
              acnt_nx  = 11'd0;
              acc_x_nx = AW'(0);
              acc_y_nx = AW'(0);
            end else begin
              scnt_nx = scnt_r + CW'(1);
            end
          end else begin
            scnt_nx = scnt_r;
          end
        end
        ACCUM: begin
          if (ce_down) begin
            acc_x_nx = sum_x_s;
            acc_y_nx = sum_y_s;
            if (acnt_r == acc_last_s) begin
              state_nx   = OUTPUT;
              acnt_nx    = 11'd0;
              resv_nx    = 1'b1;
              res_x_nx   = DW'(sum_x_s >>> k_r);
              res_y_nx   = DW'(sum_y_s >>> k_r);
              res_idx_nx = idx_r;
              res_inc_nx = phase_r;
            end else begin
              acnt_nx = acnt_r + 11'd1;
            end
          end else begin
            acnt_nx = acnt_r;
          end
        end
        OUTPUT: begin
          // Strobes arriving while the result is pending are lost.
          if (ce_down) begin
            ovr_nx = 1'b1;
          end else begin
            ovr_nx = ovr_r;
          end
          if (resv_r && res.res_ready) begin
            resv_nx = 1'b0;
            if (idx_r == nsteps_r - 16'd1) begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end else begin
              idx_nx   = idx_r + 16'd1;
              phase_nx = phase_r + step_r;
              scnt_nx  = CW'(0);
              state_nx = SETTLE;
            end
          end else begin
            resv_nx = resv_r;
          end
        end
        default: begin
          state_nx = IDLE;
          resv_nx  = 1'b0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Datapath, shadow configuration and registered outputs.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      phase_r   <= PW'(0);
      step_r    <= PW'(0);
      nsteps_r  <= 16'd0;
      settle_r  <= CW'(0);
      k_r       <= 4'd0;
      idx_r     <= 16'd0;
      scnt_r    <= CW'(0);
      acnt_r    <= 11'd0;
      acc_x_r   <= AW'(0);
      acc_y_r   <= AW'(0);
      resv_r    <= 1'b0;
      res_idx_r <= 16'd0;
      res_inc_r <= PW'(0);
      res_x_r   <= DW'(0);
      res_y_r   <= DW'(0);
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      phase_r   <= phase_nx;
      step_r    <= step_nx;
      nsteps_r  <= nsteps_nx;
      settle_r  <= settle_nx;
      k_r       <= k_nx;
      idx_r     <= idx_nx;
      scnt_r    <= scnt_nx;
      acnt_r    <= acnt_nx;
      acc_x_r   <= acc_x_nx;
      acc_y_r   <= acc_y_nx;
      resv_r    <= resv_nx;
      res_idx_r <= res_idx_nx;
      res_inc_r <= res_inc_nx;
      res_x_r   <= res_x_nx;
      res_y_r   <= res_y_nx;
      busy_r    <= (state_nx != IDLE);
      done_r    <= done_nx;
      ovr_r     <= ovr_nx;
    end
  end

  assign phase_inc_down = phase_r;
  assign res.res_valid  = resv_r;
  assign res.res_idx    = res_idx_r;
  assign res.res_inc    = res_inc_r;
  assign res.res_x      = res_x_r;
  assign res.res_y      = res_y_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign overrun        = ovr_r;

endmodule
